// File: rtl/fp32_multiplier.sv
// IEEE 754 binary32 multiplier, one registered stage, round-to-nearest-even.
// Subnormal inputs are treated as zero; underflowing results flush to zero.
module fp32_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p,
  output logic        out_valid
);

  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic        sign;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0] prod;
  logic [23:0] kept;
  logic        guard, sticky, round_up;
  logic [24:0] rounded;
  logic [9:0]  exp_norm, exp_final;
  logic [22:0] frac_final;
  logic [31:0] p_d;

  assign sign   = a[31] ^ b[31];
  assign ea     = a[30:23];
  assign eb     = b[30:23];
  assign fa     = a[22:0];
  assign fb     = b[22:0];
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  // exp=0 covers both true zero and subnormals, which are treated as zero
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);

  assign prod = {1'b1, fa} * {1'b1, fb};

  always_comb begin
    kept   = 24'd0;
    guard  = 1'b0;
    sticky = 1'b0;
    if (prod[47]) begin
      kept   = prod[47:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      kept   = prod[46:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
  end

  assign round_up = guard & (sticky | kept[0]);
  assign rounded  = {1'b0, kept} + {24'd0, round_up};

  // 10-bit signed exponent leaves headroom to detect overflow and underflow
  assign exp_norm   = {2'b00, ea} + {2'b00, eb} - 10'd127 + {9'd0, prod[47]};
  assign exp_final  = exp_norm + {9'd0, rounded[24]};
  assign frac_final = rounded[24] ? rounded[23:1] : rounded[22:0];

  always_comb begin
    p_d = {sign, exp_final[7:0], frac_final};
    if (a_nan || b_nan) begin
      p_d = QNAN;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      p_d = QNAN;
    end else if (a_inf || b_inf) begin
      p_d = {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      p_d = {sign, 31'd0};
    end else if ($signed(exp_final) >= 10'sd255) begin
      p_d = {sign, 8'hFF, 23'd0};
    end else if ($signed(exp_final) <= 10'sd0) begin
      p_d = {sign, 31'd0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p         <= 32'h00000000;
      out_valid <= 1'b0;
    end else begin
      p         <= p_d;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_fp32_multiplier.sv
// Directed bench for fp32_multiplier: reset, arithmetic, rounding, range limits,
// specials and back-to-back throughput against hand-computed products.
module tb_fp32_multiplier;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] p;
  logic        out_valid;

  int checks;
  int failures;

  fp32_multiplier dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .p         (p),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one operand pair at the falling edge, then settle just past the capturing edge.
  task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic v);
    @(negedge clk);
    a        = av;
    b        = bv;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (p !== 32'h00000000) begin
      failures++;
      $display("FAIL reset_p got=%h want=%h", p, 32'h00000000);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b want=0", out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(32'h3FC00000, 32'h40000000, 1'b1);
    checks++;
    if (p !== 32'h40400000 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL first_after_reset got=%h/%b want=40400000/1", p, out_valid);
    end
    // Mid-stream asynchronous reset: must clear without waiting for an edge
    drive(32'h40000000, 32'h40000000, 1'b1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (p !== 32'h00000000 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%h/%b want=00000000/0", p, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_arith;
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [31:0] ve [6];
    va = '{32'h44840000, 32'hC0000000, 32'h3F800001, 32'h3F800001, 32'h7F000000, 32'h00800000};
    vb = '{32'h42000000, 32'h40400000, 32'h3F800001, 32'h3FC00000, 32'h40000000, 32'h3F000000};
    ve = '{32'h47040000, 32'hC0C00000, 32'h3F800002, 32'h3FC00002, 32'h7F800000, 32'h00000000};
    for (int i = 0; i < 6; i++) begin
      drive(va[i], vb[i], 1'b1);
      checks++;
      if (p !== ve[i]) begin
        failures++;
        $display("FAIL arith[%0d] a=%h b=%h got=%h want=%h", i, va[i], vb[i], p, ve[i]);
      end
    end
    drive(32'h80800000, 32'h3F000000, 1'b1);
    checks++;
    if (p !== 32'h80000000) begin
      failures++;
      $display("FAIL neg_underflow got=%h want=80000000", p);
    end
  endtask

  task automatic test_specials;
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [31:0] ve [6];
    va = '{32'h7F800000, 32'h00000000, 32'h7FC00001, 32'hFF800000, 32'h00000001, 32'h7F800000};
    vb = '{32'h00000000, 32'hFF800000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'hFF800000};
    ve = '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h00000000, 32'hFF800000};
    for (int i = 0; i < 6; i++) begin
      drive(va[i], vb[i], 1'b1);
      checks++;
      if (p !== ve[i]) begin
        failures++;
        $display("FAIL special[%0d] a=%h b=%h got=%h want=%h", i, va[i], vb[i], p, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [31:0] ve [8];
    va = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'hBF800000,
           32'h3F000000, 32'h42000000, 32'h00000000, 32'hFF800000};
    vb = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40A00000,
           32'h3F000000, 32'h41200000, 32'hC0000000, 32'hFF800000};
    ve = '{32'h3F800000, 32'h40800000, 32'h41100000, 32'hC0A00000,
           32'h3E800000, 32'h43A00000, 32'h80000000, 32'h7F800000};
    for (int i = 0; i < 8; i++) begin
      drive(va[i], vb[i], 1'b1);
      checks++;
      if (p !== ve[i] || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b[%0d] got=%h/%b want=%h/1", i, p, out_valid, ve[i]);
      end
    end
    // p keeps updating with in_valid low; only out_valid drops
    drive(32'h3FC00000, 32'h40000000, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle_valid got=%b want=0", out_valid);
    end
    checks++;
    if (p !== 32'h40400000) begin
      failures++;
      $display("FAIL b2b_idle_p got=%h want=40400000", p);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    a        = 32'h0;
    b        = 32'h0;
    test_reset();
    test_arith();
    test_specials();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
